// File: rtl/tt_pkg.sv
// Shared types for the truth-table read-back blocks.
//   N_INPUTS_DEF / TT_W : default function arity and matching table width
//   SETTLE_W            : width of the settle counter (SETTLE_CYCLES 0..15)
//   tte_state_t         : extractor FSM states
//   truth_table_t       : full table for the default arity
package tt_pkg;
  localparam int N_INPUTS_DEF = 7;
  localparam int TT_W         = 2**N_INPUTS_DEF;
  localparam int SETTLE_W     = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tte_state_t;
  typedef logic [TT_W-1:0] truth_table_t;
endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter that flags zero; paces how long x is held before f
// is sampled.
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   load_i      : load load_val_i (wins over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; saturates at zero
//   zero_o      : count is zero
module tt_settle_counter
  import tt_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps every input vector into an external combinational function, samples
// its 1-bit output and assembles the truth table tt[i] = f(x = i). The result
// is offered on a valid/ready port.
//   clk, rst_n : clock, async active-low reset
//   start      : 1-cycle sweep request, accepted only while busy=0
//   x          : registered vector driven to the function under test
//   f          : function output, combinational from x
//   busy       : accepted start until result handshake completes
//   tt_valid   : table available (held until tt_ready)
//   tt_ready   : consumer accept
//   tt         : assembled table
// Each vector costs SETTLE_CYCLES+1 cycles (SETTLE_CYCLES in 0..15).
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_INPUTS-1:0]    x,
  input  logic                   f,
  output logic                   busy,
  output logic                   tt_valid,
  input  logic                   tt_ready,
  output logic [2**N_INPUTS-1:0] tt
);
  localparam int TTW = 2**N_INPUTS;
  // Counter is loaded on entry to SETTLE and SAMPLE follows the cycle it
  // reads zero, so loading N-1 gives exactly N settle cycles.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    SETTLE_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam tte_state_t NEXT_VEC_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [N_INPUTS-1:0] X_LAST = '1;

  tte_state_t          state_q, state_d;
  // x doubles as the table index: both advance together and never differ.
  logic [N_INPUTS-1:0] x_q, x_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [TTW-1:0]      tt_q, tt_d;
  logic                cnt_load, cnt_dec, cnt_zero;

  tt_settle_counter #(.W(SETTLE_W)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    tt_d     = tt_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        // tt is deliberately not cleared: every bit is rewritten by the sweep.
        if (start) begin
          x_d      = '0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = NEXT_VEC_ST;
        end
      end
      SETTLE: begin
        if (cnt_zero) state_d = SAMPLE;
        else          cnt_dec = 1'b1;
      end
      SAMPLE: begin
        tt_d[x_q] = f;
        if (x_q == X_LAST) begin
          // x stays all-ones after the sweep until the next start.
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          x_d      = x_q + 1'b1;
          cnt_load = 1'b1;
          state_d  = NEXT_VEC_ST;
        end
      end
      DONE: begin
        // start is ignored here even when it coincides with the handshake.
        if (tt_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      tt_q    <= tt_d;
    end
  end

  assign x        = x_q;
  assign busy     = busy_q;
  assign tt_valid = valid_q;
  assign tt       = tt_q;

`ifndef SYNTHESIS
  // An unknown f would silently poison the table; catch it in simulation.
  a_f_known: assert property (@(posedge clk) disable iff (!rst_n)
                              (state_q == SAMPLE) |-> !$isunknown(f));
`endif
endmodule

// File: tb/tb_truth_table_extractor.sv
module tb_truth_table_extractor;
  logic         clk, rst_n, tt_ready;
  logic [2:0]   start, f, busy, tt_valid;
  logic [6:0]   x  [3];
  logic [127:0] tt [3];
  int           fmode;
  logic [127:0] rand_tab;
  int           n_chk = 0, n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three DUTs: SETTLE_CYCLES = 0, 1, 3 (index 0, 1, 2).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    assign f[g] = (fmode == 3) ? rand_tab[x[g]] :
                  (fmode == 1) ? x[g][6] :
                  (fmode == 0) ? ((x[g][0] & x[g][1]) | (x[g][0] & x[g][2]) | (x[g][1] & x[g][2])) :
                  1'b0;
    truth_table_extractor #(.N_INPUTS(7), .SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .x(x[g]), .f(f[g]),
      .busy(busy[g]), .tt_valid(tt_valid[g]), .tt_ready(tt_ready), .tt(tt[g]));
  end

  function automatic int settle_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  // Reference: table built directly from the function definitions.
  function automatic logic [127:0] model(input int mode);
    logic [127:0] m;
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0:       m[i] = ($countones(i % 8) >= 2);
        1:       m[i] = (i >= 64);
        2:       m[i] = 1'b0;
        default: m[i] = rand_tab[i];
      endcase
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Returns cycles from start-accept edge to tt_valid,
  // and counts cycles where x or busy deviate from the expected sweep.
  task automatic run_sweep(input int d, output int lat, output int xbad, output int bbad);
    int s;
    s = settle_of(d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    lat = 0; xbad = 0; bbad = 0;
    while (!tt_valid[d] && lat < 4000) begin
      if (x[d] !== 7'(lat / (s + 1))) xbad++;
      if (busy[d] !== 1'b1) bbad++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int           d;
    int           mode;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t         vt [6];
  int           lat, xbad, bbad, hbad, w;
  logic [127:0] exp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = '0; tt_ready = 1'b0; fmode = 2; rand_tab = '0;
    vt[0] = '{1, 0, {16{8'hE8}}, 256};
    vt[1] = '{1, 1, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000, 256};
    vt[2] = '{1, 2, 128'h0, 256};
    vt[3] = '{0, 3, 128'h0, 128};   // random table: expectation from model
    vt[4] = '{2, 3, 128'h0, 512};
    vt[5] = '{2, 0, {16{8'hE8}}, 512};

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_x%0d", d), x[d], 0);
      chk($sformatf("rst_busy%0d", d), busy[d], 0);
      chk($sformatf("rst_valid%0d", d), tt_valid[d], 0);
      chk($sformatf("rst_tt%0d", d), tt[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // tt_ready while idle does nothing
    tt_ready = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_valid", tt_valid[1], 0);
    chk("idle_ready_busy", busy[1], 0);

    for (int e = 0; e < 6; e++) begin
      fmode = vt[e].mode;
      if (vt[e].mode == 3) begin
        rand_tab = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp = model(3);
      end else begin
        exp = vt[e].exp;
      end
      run_sweep(vt[e].d, lat, xbad, bbad);
      chk($sformatf("lat_v%0d", e), lat, vt[e].lat);
      chk($sformatf("tt_v%0d", e), tt[vt[e].d], exp);
      chk($sformatf("xseq_v%0d", e), xbad, 0);
      chk($sformatf("busy_v%0d", e), bbad, 0);
      tt_ready = 1'b1;
      @(negedge clk);
      tt_ready = 1'b0;
      chk($sformatf("hs_valid_v%0d", e), tt_valid[vt[e].d], 0);
      chk($sformatf("hs_busy_v%0d", e), busy[vt[e].d], 0);
    end

    // DONE held with tt_ready low; start pulse in the window is ignored
    fmode = 0;
    run_sweep(1, lat, xbad, bbad);
    chk("hold_lat", lat, 256);
    hbad = 0;
    for (int k = 0; k < 20; k++) begin
      start[1] = (k == 5);
      @(negedge clk);
      if (tt_valid[1] !== 1'b1 || busy[1] !== 1'b1 || tt[1] !== {16{8'hE8}}) hbad++;
    end
    start[1] = 1'b0;
    chk("done_hold", hbad, 0);
    chk("x_last_held", x[1], 7'h7F);
    tt_ready = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0;
    chk("hold_release_valid", tt_valid[1], 0);
    chk("hold_release_busy", busy[1], 0);
    @(negedge clk);
    chk("start_not_queued", busy[1], 0);

    // start together with tt_ready in DONE: handshake only
    fmode = 2;
    run_sweep(1, lat, xbad, bbad);
    chk("zero_tt", tt[1], 0);
    start[1] = 1'b1; tt_ready = 1'b1;
    @(negedge clk);
    start[1] = 1'b0; tt_ready = 1'b0;
    chk("coinc_valid", tt_valid[1], 0);
    chk("coinc_busy", busy[1], 0);
    @(negedge clk);
    chk("coinc_start_ignored", busy[1], 0);

    // back-to-back with tt_ready tied high
    tt_ready = 1'b1;
    fmode = 1;
    run_sweep(1, lat, xbad, bbad);
    chk("b2b_tt1", tt[1], 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
    @(negedge clk);
    fmode = 0;
    run_sweep(1, lat, xbad, bbad);
    chk("b2b_tt2", tt[1], {16{8'hE8}});
    chk("b2b_lat2", lat, 256);
    @(negedge clk);
    tt_ready = 1'b0;
    chk("b2b_idle_busy", busy[1], 0);

    // async reset at vector 57, then a full sweep
    fmode = 3;
    rand_tab = {$urandom(), $urandom(), $urandom(), $urandom()};
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    w = 0;
    while (x[1] !== 7'd57 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("reach_v57", (w < 1000), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_x", x[1], 0);
    chk("arst_busy", busy[1], 0);
    chk("arst_valid", tt_valid[1], 0);
    chk("arst_tt", tt[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(1, lat, xbad, bbad);
    chk("post_rst_lat", lat, 256);
    chk("post_rst_tt", tt[1], model(3));
    chk("post_rst_xseq", xbad, 0);
    tt_ready = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0;
    chk("post_rst_hs", tt_valid[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
